// File: rtl/sdspi_apb_arb.sv
// Two-master APB arbiter sharing the SD-SPI controller port: boot-loader priority
// until boot completes, then round-robin, with per-master lock and a pready watchdog.
module sdspi_apb_arb #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk27mhz,
    input  logic              resetn,
    input  logic              boot_done,
    input  logic              m0_psel,
    input  logic              m0_pwrite,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic [DATA_W-1:0] m0_pwdata,
    input  logic              m0_lock,
    output logic [DATA_W-1:0] m0_prdata,
    output logic              m0_pready,
    output logic              m0_pslverr,
    input  logic              m1_psel,
    input  logic              m1_pwrite,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic [DATA_W-1:0] m1_pwdata,
    input  logic              m1_lock,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              m1_pready,
    output logic              m1_pslverr,
    output logic              s_psel,
    output logic              s_penable,
    output logic              s_pwrite,
    output logic [ADDR_W-1:0] s_paddr,
    output logic [DATA_W-1:0] s_pwdata,
    input  logic [DATA_W-1:0] s_prdata,
    input  logic              s_pready,
    input  logic              s_pslverr,
    output logic [31:0]       arb_status
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_TURN   = 3'd4
    } state_t;

    // Watchdog holds (ACCESS cycles seen - 1); it only needs to reach TIMEOUT-1.
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              lock_active_q, lock_active_d;
    logic [15:0]       timeout_cnt_q, timeout_cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              s_psel_q, s_psel_d;
    logic              s_penable_q, s_penable_d;
    logic              s_pwrite_q, s_pwrite_d;
    logic [ADDR_W-1:0] s_paddr_q, s_paddr_d;
    logic [DATA_W-1:0] s_pwdata_q, s_pwdata_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pslverr_q, pslverr_d;
    logic              m0_pready_q, m0_pready_d;
    logic              m1_pready_q, m1_pready_d;

    logic              owner_lock;
    logic              grant_v;
    logic              grant_id;
    logic              finish;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        lock_active_d = lock_active_q;
        timeout_cnt_d = timeout_cnt_q;
        wd_d          = wd_q;
        s_psel_d      = s_psel_q;
        s_penable_d   = s_penable_q;
        s_pwrite_d    = s_pwrite_q;
        s_paddr_d     = s_paddr_q;
        s_pwdata_d    = s_pwdata_q;
        prdata_d      = prdata_q;
        pslverr_d     = pslverr_q;
        m0_pready_d   = 1'b0;
        m1_pready_d   = 1'b0;
        owner_lock    = owner_q ? m1_lock : m0_lock;
        grant_v       = 1'b0;
        grant_id      = 1'b0;
        finish        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                lock_active_d = lock_active_q & owner_lock;
                if (lock_active_d) begin
                    grant_v  = owner_q ? m1_psel : m0_psel;
                    grant_id = owner_q;
                end else if (m0_psel && m1_psel) begin
                    grant_v  = 1'b1;
                    grant_id = boot_done ? ~last_grant_q : 1'b0;
                end else begin
                    grant_v  = m0_psel | m1_psel;
                    grant_id = ~m0_psel;
                end
                if (grant_v) begin
                    owner_d     = grant_id;
                    s_pwrite_d  = grant_id ? m1_pwrite : m0_pwrite;
                    s_paddr_d   = grant_id ? m1_paddr  : m0_paddr;
                    s_pwdata_d  = grant_id ? m1_pwdata : m0_pwdata;
                    s_psel_d    = 1'b1;
                    s_penable_d = 1'b0;
                    wd_d        = '0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                s_penable_d = 1'b1;
                state_d     = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A pready arriving on the last allowed cycle still counts as a completion.
                if (s_pready) begin
                    prdata_d  = s_prdata;
                    pslverr_d = s_pslverr;
                    finish    = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                    if (timeout_cnt_q != 16'hFFFF) begin
                        timeout_cnt_d = timeout_cnt_q + 16'd1;
                    end
                    finish = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
                if (finish) begin
                    s_psel_d    = 1'b0;
                    s_penable_d = 1'b0;
                    m0_pready_d = ~owner_q;
                    m1_pready_d = owner_q;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                last_grant_d  = owner_q;
                lock_active_d = owner_lock;
                state_d       = ST_TURN;
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments and a synchronous reset, so a
    // reset mid-transfer simply abandons the bus on the next edge.
    always_ff @(posedge clk27mhz) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            lock_active_q <= 1'b0;
            timeout_cnt_q <= '0;
            wd_q          <= '0;
            s_psel_q      <= 1'b0;
            s_penable_q   <= 1'b0;
            s_pwrite_q    <= 1'b0;
            s_paddr_q     <= '0;
            s_pwdata_q    <= '0;
            prdata_q      <= '0;
            pslverr_q     <= 1'b0;
            m0_pready_q   <= 1'b0;
            m1_pready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            lock_active_q <= lock_active_d;
            timeout_cnt_q <= timeout_cnt_d;
            wd_q          <= wd_d;
            s_psel_q      <= s_psel_d;
            s_penable_q   <= s_penable_d;
            s_pwrite_q    <= s_pwrite_d;
            s_paddr_q     <= s_paddr_d;
            s_pwdata_q    <= s_pwdata_d;
            prdata_q      <= prdata_d;
            pslverr_q     <= pslverr_d;
            m0_pready_q   <= m0_pready_d;
            m1_pready_q   <= m1_pready_d;
        end
    end

    assign s_psel     = s_psel_q;
    assign s_penable  = s_penable_q;
    assign s_pwrite   = s_pwrite_q;
    assign s_paddr    = s_paddr_q;
    assign s_pwdata   = s_pwdata_q;
    assign m0_pready  = m0_pready_q;
    assign m1_pready  = m1_pready_q;
    assign m0_prdata  = prdata_q;
    assign m1_prdata  = prdata_q;
    assign m0_pslverr = pslverr_q;
    assign m1_pslverr = pslverr_q;
    assign arb_status = {timeout_cnt_q, 5'b0, lock_active_q, owner_q, last_grant_q, 5'b0, state_q};
endmodule

// File: tb/tb_sdspi_apb_arb.sv
// Self-checking bench for sdspi_apb_arb: directed scenarios plus random traffic,
// all compared cycle by cycle against a transfer-level reference model.
module tb_sdspi_apb_arb;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk27mhz = 1'b0;
    logic              resetn;
    logic              boot_done;
    logic              m0_psel, m0_pwrite, m0_lock, m0_pready, m0_pslverr;
    logic [ADDR_W-1:0] m0_paddr;
    logic [DATA_W-1:0] m0_pwdata, m0_prdata;
    logic              m1_psel, m1_pwrite, m1_lock, m1_pready, m1_pslverr;
    logic [ADDR_W-1:0] m1_paddr;
    logic [DATA_W-1:0] m1_pwdata, m1_prdata;
    logic              s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
    logic [ADDR_W-1:0] s_paddr;
    logic [DATA_W-1:0] s_pwdata, s_prdata;
    logic [31:0]       arb_status;

    always #18 clk27mhz = ~clk27mhz;

    sdspi_apb_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk27mhz(clk27mhz), .resetn(resetn), .boot_done(boot_done),
        .m0_psel(m0_psel), .m0_pwrite(m0_pwrite), .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata),
        .m0_lock(m0_lock), .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_pwrite(m1_pwrite), .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata),
        .m1_lock(m1_lock), .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite), .s_paddr(s_paddr),
        .s_pwdata(s_pwdata), .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .arb_status(arb_status)
    );

    // w = slave wait cycles; w >= TIMEOUT means the transfer ends on the watchdog.
    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                w;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    logic lk0, lk1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   random_mode = 1'b0;

    // Reference model: one transfer in flight, known grant and done cycles.
    bit   mb_busy, mb_to, mb_lock;
    int   mb_g, mb_d, mb_idle_at, mb_owner, mb_last, mb_tcnt;
    txn_t mb_t;

    int              hist_dut[$];
    int              hist_mdl[$];
    int              rdy_cyc[2];
    logic [DATA_W-1:0] rdy_data[2];
    logic            rdy_err[2];
    int              pen_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int hd(input int i);
        return (i < hist_dut.size()) ? hist_dut[i] : -1;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   r;
        t.wr    = 1'($urandom_range(0, 1));
        t.addr  = ADDR_W'($urandom);
        t.wdata = $urandom;
        t.rdata = $urandom;
        t.err   = ($urandom_range(0, 7) == 0);
        r = $urandom_range(0, 9);
        if (r <= 5)      t.w = $urandom_range(0, 3);
        else if (r == 6) t.w = TIMEOUT - 1;
        else if (r == 7) t.w = TIMEOUT;
        else if (r == 8) t.w = 50;
        else             t.w = 0;
        return t;
    endfunction

    function automatic txn_t mk(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int w);
        txn_t t;
        t.wr = 1'b0; t.addr = a; t.wdata = ~d; t.rdata = d; t.err = 1'b0; t.w = w;
        return t;
    endfunction

    task automatic compare();
        logic done_now, exp_sel, exp_en;
        logic [23:0] exp_stat;
        done_now = mb_busy && (cyc == mb_d);
        exp_sel  = mb_busy && (cyc > mb_g) && (cyc < mb_d);
        exp_en   = mb_busy && (cyc > mb_g + 1) && (cyc < mb_d);
        check("s_psel", 64'(s_psel), 64'(exp_sel));
        check("s_penable", 64'(s_penable), 64'(exp_en));
        check("m0_pready", 64'(m0_pready), 64'(done_now && mb_owner == 0));
        check("m1_pready", 64'(m1_pready), 64'(done_now && mb_owner == 1));
        if (exp_sel) begin
            check("s_paddr", 64'(s_paddr), 64'(mb_t.addr));
            check("s_pwdata", 64'(s_pwdata), 64'(mb_t.wdata));
            check("s_pwrite", 64'(s_pwrite), 64'(mb_t.wr));
        end
        if (done_now) begin
            check("m0_prdata", 64'(m0_prdata), mb_to ? 64'd0 : 64'(mb_t.rdata));
            check("m1_prdata", 64'(m1_prdata), mb_to ? 64'd0 : 64'(mb_t.rdata));
            check("pslverr", 64'(mb_owner == 0 ? m0_pslverr : m1_pslverr), mb_to ? 64'd1 : 64'(mb_t.err));
            hist_mdl.push_back(mb_owner);
        end
        exp_stat = {mb_tcnt[15:0], 5'b0, mb_lock, 1'(mb_owner), 1'(mb_last)};
        check("arb_status", 64'(arb_status[31:8]), 64'(exp_stat));
        if (m0_pready) begin
            hist_dut.push_back(0); rdy_cyc[0] = cyc; rdy_data[0] = m0_prdata; rdy_err[0] = m0_pslverr;
        end
        if (m1_pready) begin
            hist_dut.push_back(1); rdy_cyc[1] = cyc; rdy_data[1] = m1_prdata; rdy_err[1] = m1_pslverr;
        end
        if (s_penable) pen_cnt++;
    endtask

    task automatic stimulus();
        if (mb_busy && cyc == mb_d) begin
            if (mb_owner == 0) q0.delete(0);
            else               q1.delete(0);
        end
        if (random_mode) begin
            if (q0.size() < 3 && $urandom_range(0, 5) == 0) q0.push_back(rand_txn());
            if (q1.size() < 3 && $urandom_range(0, 5) == 0) q1.push_back(rand_txn());
            if ($urandom_range(0, 24) == 0) lk0 = ~lk0;
            if ($urandom_range(0, 24) == 0) lk1 = ~lk1;
            if ($urandom_range(0, 99) == 0) boot_done = ~boot_done;
        end
        m0_psel = (q0.size() != 0);
        m1_psel = (q1.size() != 0);
        if (m0_psel) begin
            m0_pwrite = q0[0].wr; m0_paddr = q0[0].addr; m0_pwdata = q0[0].wdata;
        end else begin
            m0_pwrite = 1'($urandom); m0_paddr = ADDR_W'($urandom); m0_pwdata = $urandom;
        end
        if (m1_psel) begin
            m1_pwrite = q1[0].wr; m1_paddr = q1[0].addr; m1_pwdata = q1[0].wdata;
        end else begin
            m1_pwrite = 1'($urandom); m1_paddr = ADDR_W'($urandom); m1_pwdata = $urandom;
        end
        m0_lock = lk0;
        m1_lock = lk1;
        if (mb_busy && cyc == mb_g + 2 + mb_t.w) begin
            s_pready = 1'b1; s_prdata = mb_t.rdata; s_pslverr = mb_t.err;
        end else begin
            s_pready = 1'b0; s_prdata = $urandom; s_pslverr = 1'($urandom);
        end
    endtask

    // Decides what the arbiter does at the edge closing the current cycle.
    task automatic model_step();
        bit r0, r1;
        int win;
        r0 = (q0.size() != 0);
        r1 = (q1.size() != 0);
        win = -1;
        if (mb_busy) begin
            if (mb_to && cyc == mb_d - 1 && mb_tcnt < 65535) mb_tcnt++;
            if (cyc == mb_d) begin
                mb_last    = mb_owner;
                mb_lock    = (mb_owner == 0) ? lk0 : lk1;
                mb_busy    = 1'b0;
                mb_idle_at = cyc + 2;
            end
        end else if (cyc >= mb_idle_at) begin
            mb_lock = mb_lock && ((mb_owner == 0) ? lk0 : lk1);
            if (mb_lock) begin
                if ((mb_owner == 0) ? r0 : r1) win = mb_owner;
            end else if (r0 && r1) begin
                win = boot_done ? 1 - mb_last : 0;
            end else if (r0) begin
                win = 0;
            end else if (r1) begin
                win = 1;
            end
            if (win >= 0) begin
                mb_owner = win;
                mb_t     = (win == 0) ? q0[0] : q1[0];
                mb_g     = cyc;
                mb_to    = (mb_t.w >= TIMEOUT);
                mb_d     = mb_to ? cyc + 2 + TIMEOUT : cyc + 3 + mb_t.w;
                mb_busy  = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk27mhz);
        #1;
        cyc++;
        compare();
        stimulus();
        model_step();
    endtask

    task automatic apply_reset(input int n);
        resetn = 1'b0;
        repeat (n) begin
            @(posedge clk27mhz);
            #1;
            cyc++;
            check("rst_s_bus", 64'({s_psel, s_penable, s_pwrite, s_paddr, s_pwdata}), 64'd0);
            check("rst_m_rsp", 64'({m0_pready, m1_pready, m0_pslverr, m1_pslverr}), 64'd0);
            check("rst_prdata", 64'({m0_prdata, m1_prdata}), 64'd0);
            check("rst_status", 64'(arb_status), 64'h0000_0100);
        end
        resetn     = 1'b1;
        mb_busy    = 1'b0;
        mb_to      = 1'b0;
        mb_lock    = 1'b0;
        mb_owner   = 0;
        mb_last    = 1;
        mb_tcnt    = 0;
        mb_idle_at = cyc;
        stimulus();
        model_step();
    endtask

    task automatic run_xfers(input int n, input int budget);
        int b;
        b = 0;
        while (hist_mdl.size() < n && b < budget) begin
            tick();
            b++;
        end
        check("xfer_budget", 64'(hist_mdl.size() >= n), 64'd1);
    endtask

    initial begin
        int t, h;
        resetn = 1'b0; boot_done = 1'b0; lk0 = 1'b0; lk1 = 1'b0;
        m0_psel = 1'b0; m0_pwrite = 1'b0; m0_paddr = '0; m0_pwdata = '0; m0_lock = 1'b0;
        m1_psel = 1'b0; m1_pwrite = 1'b0; m1_paddr = '0; m1_pwdata = '0; m1_lock = 1'b0;
        s_prdata = '0; s_pready = 1'b0; s_pslverr = 1'b0;
        mb_g = 0; mb_d = 0; mb_t = mk('0, '0, 0);
        rdy_cyc = '{default: -1}; rdy_data = '{default: '0}; rdy_err = '{default: 1'b0};

        // Single read from m0 with two wait cycles.
        apply_reset(2);
        q0.push_back(mk(16'h0200, 32'h0000_00A5, 2));
        t = cyc + 1;
        pen_cnt = 0;
        run_xfers(1, 30);
        check("rd_pready_cycle", 64'(rdy_cyc[0]), 64'(t + 5));
        check("rd_prdata", 64'(rdy_data[0]), 64'h0000_00A5);
        check("rd_penable_cycles", 64'(pen_cnt), 64'd3);

        // Boot-time strict priority for m0.
        apply_reset(1);
        hist_dut.delete(); hist_mdl.delete();
        for (int i = 0; i < 3; i++) q0.push_back(mk(16'h0100 + 16'(i), 32'h1000 + 32'(i), i));
        q1.push_back(mk(16'h0300, 32'h2000, 1));
        run_xfers(4, 80);
        check("prio_count", 64'(hist_dut.size()), 64'd4);
        check("prio_g0", 64'(hd(0)), 64'd0);
        check("prio_g1", 64'(hd(1)), 64'd0);
        check("prio_g2", 64'(hd(2)), 64'd0);
        check("prio_g3", 64'(hd(3)), 64'd1);

        // Round-robin after boot, m0 first after reset.
        apply_reset(1);
        boot_done = 1'b1;
        hist_dut.delete(); hist_mdl.delete();
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk(16'h0400 + 16'(i), 32'h3000 + 32'(i), 0));
            q1.push_back(mk(16'h0500 + 16'(i), 32'h4000 + 32'(i), 1));
        end
        run_xfers(4, 80);
        check("rr_count", 64'(hist_dut.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("rr_grant", 64'(hd(i)), 64'(i % 2));

        // m0 lock over four transfers while m1 waits.
        apply_reset(1);
        hist_dut.delete(); hist_mdl.delete();
        lk0 = 1'b1;
        for (int i = 0; i < 4; i++) q0.push_back(mk(16'h0600 + 16'(i), 32'h5000 + 32'(i), 0));
        q1.push_back(mk(16'h0700, 32'h6000, 1));
        run_xfers(4, 80);
        lk0 = 1'b0;
        run_xfers(5, 40);
        check("lock_count", 64'(hist_dut.size()), 64'd5);
        for (int i = 0; i < 4; i++) check("lock_grant_m0", 64'(hd(i)), 64'd0);
        check("lock_grant_m1", 64'(hd(4)), 64'd1);
        check("lock_m1_cycle", 64'(rdy_cyc[1]), 64'(rdy_cyc[0] + 6));

        // Watchdog: slave never answers m1.
        apply_reset(1);
        boot_done = 1'b0;
        q1.push_back(mk(16'h0800, 32'hDEAD_BEEF, 50));
        t = cyc + 1;
        h = hist_mdl.size();
        run_xfers(h + 1, 40);
        check("to_pready_cycle", 64'(rdy_cyc[1]), 64'(t + 10));
        check("to_pslverr", 64'(rdy_err[1]), 64'd1);
        check("to_prdata", 64'(rdy_data[1]), 64'd0);
        check("to_count", 64'(arb_status[31:16]), 64'd1);

        // Reset during ACCESS abandons the transfer; the request then completes.
        apply_reset(1);
        q0.push_back(mk(16'h0900, 32'h0BAD_F00D, 50));
        repeat (4) tick();
        check("mid_in_access", 64'(s_penable), 64'd1);
        h = hist_dut.size();
        q0[0].w = 1;
        apply_reset(1);
        check("mid_no_pready", 64'(hist_dut.size()), 64'(h));
        run_xfers(hist_mdl.size() + 1, 30);
        check("mid_after_count", 64'(hist_dut.size()), 64'(h + 1));
        check("mid_after_data", 64'(rdy_data[0]), 64'h0BAD_F00D);

        // Random traffic, lock and boot_done changes against the model.
        apply_reset(1);
        random_mode = 1'b1;
        repeat (1500) tick();
        random_mode = 1'b0;
        check("rand_sane", 64'(hist_dut.size() > 20), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
